crtc: RTL and testbench

//  Parametrised CRT controller: successor to the fixed 640x480 VGA timing logic in the tivi video card.

---
 rtl/tivi_video_pkg.sv | 24 ++
 rtl/crtc_axis.sv | 50 +++++
 rtl/crtc.sv | 135 +++++++++++++
 tb/tb_crtc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tivi_video_pkg.sv
// Shared video timing constants and helpers for the tivi video card.
// Default mode is 640x480@60; the CRT controller takes any mode through parameters.
package tivi_video_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam bit SYNC_NEG = 1'b0;
    localparam bit SYNC_POS = 1'b1;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/crtc_axis.sv
// One timing axis (horizontal or vertical): wrapping counter with registered blank/sync.
// next_count exposes the value the counter takes at the coming edge so the parent can align its outputs.
module crtc_axis
    import tivi_video_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter bit POL    = SYNC_NEG,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] next_count,
    output logic         blank,
    output logic         sync,
    output logic         wrap
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

    assign wrap = inc && (count == LAST);

    always_comb begin
        next_count = count;
        if (inc) begin
            next_count = (count == LAST) ? '0 : count + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= LAST;
            blank <= 1'b1;
            sync  <= ~POL;
        end else if (inc) begin
            count <= next_count;
            blank <= (next_count >= ACT_END);
            sync  <= (next_count >= SYNC_LO && next_count < SYNC_HI) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/crtc.sv
// Parametrised CRT controller: syncs, blanking, position, text cell addressing with scroll, cursor blink.
// Define RASTER_IRQ_EN to enable the sticky raster interrupt; otherwise irq is tied low.
module crtc
    import tivi_video_pkg::*;
#(
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_FP         = VGA_H_FP,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BP         = VGA_H_BP,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_FP         = VGA_V_FP,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BP         = VGA_V_BP,
    parameter bit H_POL        = SYNC_NEG,
    parameter bit V_POL        = SYNC_NEG,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int ADDR_W       = 14,
    parameter int FETCH_LEAD   = 2,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_en,
    input  logic [ADDR_W-1:0]         start_addr,
    input  logic [7:0]                line_stride,
    input  logic [9:0]                irq_line,
    input  logic                      irq_ack,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      hblank,
    output logic                      vblank,
    output logic                      de,
    output logic [9:0]                x,
    output logic [9:0]                y,
    output logic [ADDR_W-1:0]         cell_addr,
    output logic [$clog2(CHAR_H)-1:0] glyph_row,
    output logic                      line_start,
    output logic                      frame_start,
    output logic                      blink,
    output logic                      irq
);

    localparam int GR_W    = $clog2(CHAR_H);
    localparam int CW_SH   = $clog2(CHAR_W);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [9:0]         x_next, y_next;
    logic               h_wrap, v_wrap_unused;
    logic               line_start_next, frame_start_next;
    logic [10:0]        fetch_x;
    logic [ADDR_W-1:0]  row_base_reg, row_base_next, cell_addr_next;
    logic [BLINK_W-1:0] blink_cnt_reg;

    crtc_axis #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .W(10)
    ) u_h (
        .clk(clk), .reset(reset), .inc(pix_en),
        .count(x), .next_count(x_next), .blank(hblank), .sync(hsync), .wrap(h_wrap)
    );

    crtc_axis #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .W(10)
    ) u_v (
        .clk(clk), .reset(reset), .inc(h_wrap),
        .count(y), .next_count(y_next), .blank(vblank), .sync(vsync), .wrap(v_wrap_unused)
    );

    assign de = ~hblank & ~vblank;

    // Everything below is derived from the next-state position so it lines up with x/y.
    always_comb begin
        line_start_next  = pix_en && (x_next == '0);
        frame_start_next = line_start_next && (y_next == '0);
        fetch_x          = {1'b0, x_next} + 11'(FETCH_LEAD);

        row_base_next = row_base_reg;
        if (frame_start_next) begin
            row_base_next = start_addr;
        end else if (line_start_next && y_next[GR_W-1:0] == '0 && y_next < 10'(V_ACTIVE)) begin
            row_base_next = row_base_reg + ADDR_W'(line_stride);
        end

        cell_addr_next = cell_addr;
        if (pix_en && fetch_x < 11'(H_ACTIVE)) begin
            cell_addr_next = row_base_next + ADDR_W'(fetch_x >> CW_SH);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_base_reg  <= '0;
            cell_addr     <= '0;
            glyph_row     <= '0;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            blink         <= 1'b0;
            blink_cnt_reg <= '0;
        end else begin
            line_start  <= line_start_next;
            frame_start <= frame_start_next;
            if (pix_en) begin
                row_base_reg <= row_base_next;
                cell_addr    <= cell_addr_next;
                glyph_row    <= y_next[GR_W-1:0];
            end
            if (frame_start_next) begin
                if (blink_cnt_reg == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt_reg <= '0;
                    blink         <= ~blink;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
                end
            end
        end
    end

`ifdef RASTER_IRQ_EN
    // Acknowledge is honoured on every clock; a simultaneous set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (line_start_next && y_next == irq_line) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`else
    logic unused_irq;
    assign unused_irq = ^{irq_line, irq_ack};
    assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_crtc.sv
// Scoreboard bench for crtc on a reduced 100x48 mode; stimulus pushes expected outputs, a monitor compares.
module tb_crtc;

    localparam int HA = 80, HFP = 4, HS = 8, HBP = 8;
    localparam int VA = 40, VFP = 2, VS = 2, VBP = 4;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int CW = 8, CH = 16, FL = 2, BF = 2;
    localparam int STRIDE = 80, IRQ_LINE = 20;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1, pix_en = 1'b0, irq_ack = 1'b0;
    logic [13:0] start_addr = '0;
    logic [7:0]  line_stride = 8'(STRIDE);
    logic [9:0]  irq_line = 10'(IRQ_LINE);
    logic        hsync, vsync, hblank, vblank, de, line_start, frame_start, blink, irq;
    logic [9:0]  x, y;
    logic [13:0] cell_addr;
    logic [3:0]  glyph_row;

    always #5 clk = ~clk;

    crtc #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .H_POL(1'b0), .V_POL(1'b0), .CHAR_W(CW), .CHAR_H(CH),
        .ADDR_W(14), .FETCH_LEAD(FL), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .start_addr(start_addr),
        .line_stride(line_stride), .irq_line(irq_line), .irq_ack(irq_ack),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de),
        .x(x), .y(y), .cell_addr(cell_addr), .glyph_row(glyph_row),
        .line_start(line_start), .frame_start(frame_start), .blink(blink), .irq(irq)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs, vs, hb, vb, de;
        logic [13:0] addr;
        logic [3:0]  gr;
        logic        ls, fs, blink, irq;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int   tests = 0, fails = 0;

    int          mx = HT - 1, my = VT - 1, fs_cnt = 0;
    logic [13:0] sa_drive = 14'h1000, sa_frame = '0, m_addr = '0;
    logic        m_ls = 1'b0, m_fs = 1'b0, m_irq = 1'b0, fresh = 1'b1;

    task automatic check(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (x=%0d y=%0d)", nm, got, want, x, y);
        end
    endtask

    function automatic logic [13:0] addr_of(input int xx, input int yy, input logic [13:0] base0);
        int row, col, sum;
        row = ((yy < VA) ? yy : VA - 1) / CH;
        col = (xx + FL < HA) ? (xx + FL) / CW : (HA - 1) / CW;
        sum = int'(base0) + row * STRIDE + col;
        return 14'(sum % 16384);
    endfunction

    // Hand-computed spot values, sampled just after the edge that produced them.
    task automatic spot();
        #6;
        if (mx == 0 && my == 0) begin
            $display("[TB] frame %0d started at t=%0t", fs_cnt, $time);
            check("frame_start", frame_start, 1);
            if (fs_cnt == 1) check("addr_frame1_origin", cell_addr, 'h1000);
            if (fs_cnt == 2) check("addr_frame2_origin", cell_addr, 'h3FF8);
            if (fs_cnt == 2) check("blink_after_2", blink, 1);
            if (fs_cnt == 4) check("blink_after_4", blink, 0);
        end
        if (fs_cnt == 1) begin
            if (my == 0  && mx == 6)  check("addr_y0_x6", cell_addr, 'h1001);
            if (my == 16 && mx == 0)  check("addr_row1", cell_addr, 'h1050);
            if (my == 21 && mx == 0)  check("addr_sa_write_ignored", cell_addr, 'h1050);
            if (my == 32 && mx == 0)  check("addr_row2", cell_addr, 'h10A0);
            if (my == 44 && mx == 0)  check("addr_vblank_hold", cell_addr, 'h10A0);
            if (my == 0  && mx == 83) check("hsync_before", hsync, 1);
            if (my == 0  && mx == 84) check("hsync_first", hsync, 0);
            if (my == 0  && mx == 91) check("hsync_last", hsync, 0);
            if (my == 0  && mx == 92) check("hsync_after", hsync, 1);
            if (my == 42 && mx == 0)  check("vsync_in", vsync, 0);
            if (my == 44 && mx == 0)  check("vsync_after", vsync, 1);
            if (my == 39 && mx == 0)  check("vblank_last_active", vblank, 0);
            if (my == 40 && mx == 0)  check("vblank_first", vblank, 1);
            if (my == 3  && mx == 79) check("de_last", de, 1);
            if (my == 3  && mx == 80) check("de_hblank", de, 0);
        end
        if (fs_cnt == 2 && my == 0) begin
            if (mx == 54) check("addr_wrap_top", cell_addr, 'h3FFF);
            if (mx == 62) check("addr_wrap_zero", cell_addr, 'h0000);
            if (mx == 70) check("addr_wrap_one", cell_addr, 'h0001);
        end
`ifdef RASTER_IRQ_EN
        if (fs_cnt == 2 && my == IRQ_LINE && mx == 0) check("irq_set_with_ack", irq, 1);
        if (fs_cnt == 2 && my == 25 && mx == 11)      check("irq_acked", irq, 0);
`else
        if (my == IRQ_LINE && mx == 0) check("irq_tied_low", irq, 0);
`endif
    endtask

    task automatic step(input logic pe, input logic rs, input logic ack);
        obs_t e;
        @(negedge clk);
        pix_en = pe; reset = rs; irq_ack = ack; start_addr = sa_drive;
        m_ls = 1'b0; m_fs = 1'b0;
        if (rs) begin
            mx = HT - 1; my = VT - 1; fs_cnt = 0;
            m_irq = 1'b0; m_addr = '0; fresh = 1'b1;
        end else begin
            if (pe) begin
                if (mx == HT - 1) begin
                    mx = 0;
                    my = (my == VT - 1) ? 0 : my + 1;
                end else begin
                    mx++;
                end
                m_ls = (mx == 0);
                m_fs = m_ls && (my == 0);
                if (m_fs) begin
                    sa_frame = sa_drive;
                    fs_cnt++;
                end
                m_addr = addr_of(mx, my, sa_frame);
                fresh  = 1'b0;
            end
`ifdef RASTER_IRQ_EN
            if (m_ls && my == IRQ_LINE) m_irq = 1'b1;
            else if (ack)               m_irq = 1'b0;
`endif
        end
        e.x     = 10'(mx);
        e.y     = 10'(my);
        e.hb    = (mx >= HA);
        e.vb    = (my >= VA);
        e.de    = !e.hb && !e.vb;
        e.hs    = !(mx >= HA + HFP && mx < HA + HFP + HS);
        e.vs    = !(my >= VA + VFP && my < VA + VFP + VS);
        e.addr  = fresh ? 14'h0 : m_addr;
        e.gr    = fresh ? 4'h0 : 4'(my % CH);
        e.ls    = m_ls;
        e.fs    = m_fs;
        e.blink = ((fs_cnt / BF) % 2) == 1;
        e.irq   = m_irq;
        exp_q.push_back(e);
        if (pe && !rs) spot();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {x, y, hsync, vsync, hblank, vblank, de, cell_addr, glyph_row,
                         line_start, frame_start, blink, irq};
                tests++;
                if (mon_a !== mon_e) begin
                    fails++;
                    $display("FAIL outputs t=%0t: got x=%0d y=%0d hs=%b vs=%b hb=%b vb=%b de=%b addr=%h gr=%0d ls=%b fs=%b bl=%b irq=%b, want x=%0d y=%0d hs=%b vs=%b hb=%b vb=%b de=%b addr=%h gr=%0d ls=%b fs=%b bl=%b irq=%b",
                             $time, mon_a.x, mon_a.y, mon_a.hs, mon_a.vs, mon_a.hb, mon_a.vb, mon_a.de,
                             mon_a.addr, mon_a.gr, mon_a.ls, mon_a.fs, mon_a.blink, mon_a.irq,
                             mon_e.x, mon_e.y, mon_e.hs, mon_e.vs, mon_e.hb, mon_e.vb, mon_e.de,
                             mon_e.addr, mon_e.gr, mon_e.ls, mon_e.fs, mon_e.blink, mon_e.irq);
                end
            end
        end
    end

    initial begin
        bit held;
        logic ack;
        held = 1'b0;
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // Frame 1 at half pixel rate; start_addr rewritten mid-frame.
        for (int n = 0; n < FRAME; n++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            if (my == 20 && mx == 0) sa_drive = 14'h3FF8;
        end

        // Frames 2..4 at full rate: address wrap, mid-line hold, irq ack, blink.
        for (int n = 0; n < 3 * FRAME; n++) begin
            ack = (fs_cnt == 2) && ((mx == HT - 1 && my == IRQ_LINE - 1) || (mx == 10 && my == 25));
            step(1'b1, 1'b0, ack);
            if (fs_cnt == 2 && my == 5 && mx == 30 && !held) begin
                held = 1'b1;
                repeat (50) step(1'b0, 1'b0, 1'b0);
            end
        end

        // Mid-frame reset, then restart.
        for (int n = 0; n < FRAME && !(fs_cnt == 5 && my == 10); n++) step(1'b1, 1'b0, 1'b0);
        sa_drive = 14'h1000;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
